// File: rtl/vadd_stream_driver.sv
// vadd_stream_driver: drives the vadd kernel input stream and checks its decrementing output stream
// Ports: clk, reset_n (async, active-low); start/rx_stall control; busy/done/error/mismatch_cnt/beat_cnt status;
// kernel_in_* feeds chunks to the kernel, kernel_out_* accepts and compares its output beats.
// Optional: define DRV_TIMEOUT_EN to abort a run after TIMEOUT_CYCLES cycles without an accepted beat.
module vadd_stream_driver #(
  parameter int C_DATA_WIDTH   = 512,
  parameter int NUM_CHUNKS     = 4,
  parameter int REPS           = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    rx_stall,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             mismatch_cnt,
  output logic [31:0]             beat_cnt,
  input  logic                    kernel_in_ready,
  output logic                    kernel_in_avail,
  output logic [C_DATA_WIDTH-1:0] kernel_in_data,
  output logic                    kernel_out_ready,
  input  logic                    kernel_out_avail,
  input  logic [C_DATA_WIDTH-1:0] kernel_out_data
);
  localparam int NW = C_DATA_WIDTH / 32;
  localparam logic [7:0] REPS8 = 8'(REPS);
  localparam logic [15:0] LAST = 16'(NUM_CHUNKS - 1);
  // words 2..4 carry kernel debug/size fields and are never compared
  localparam logic [NW-1:0] MASK = ~NW'(28);
  if (C_DATA_WIDTH % 32 != 0 || C_DATA_WIDTH < 192 || NUM_CHUNKS < 1 || NUM_CHUNKS > 65535 ||
      REPS < 1 || REPS > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("vadd_stream_driver: parameter out of range");
  end
  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
  state_t state;
  logic [15:0] k;
  logic [7:0] j, j_nx;
  logic [NW-1:0] ne;
  logic in_acc, out_acc, bad, last_beat, adv, timeout;
  function automatic logic [31:0] in_word(input logic [15:0] c, input int i);
    return {c, i[7:0], REPS8};
  endfunction
  assign busy = state == SEND || state == RECV;
  assign done = state == DONE;
  assign kernel_in_avail = state == SEND;
  assign kernel_out_ready = busy && !rx_stall;
  assign in_acc = kernel_in_avail && kernel_in_ready;
  assign out_acc = kernel_out_ready && kernel_out_avail;
  assign j_nx = j + 8'd1;
  assign bad = |(ne & MASK);
  assign last_beat = out_acc && j_nx == REPS8;
  // the kernel answers combinationally, so the final beat of a chunk may land in the SEND cycle itself
  assign adv = last_beat && (state == RECV || (state == SEND && in_acc));
  always_comb begin
    kernel_in_data = '0;
    ne = '0;
    for (int i = 0; i < NW; i++) begin
      kernel_in_data[32*i +: 32] = state == SEND ? in_word(k, i) : 32'd0;
      ne[i] = kernel_out_data[32*i +: 32] != in_word(k, i) - {24'd0, j_nx};
    end
  end
`ifdef DRV_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_cnt <= '0;
    else to_cnt <= (!busy || in_acc || out_acc) ? '0 : to_cnt + 32'd1;
  end
  assign timeout = busy && !in_acc && !out_acc && to_cnt == 32'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      error <= 1'b0;
      mismatch_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (out_acc) begin
        j <= j_nx;
        beat_cnt <= beat_cnt + 32'd1;
        if (bad && mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
        if (bad || (state == SEND && !in_acc)) error <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= SEND;
            k <= '0;
            j <= '0;
            error <= kernel_out_avail;
            mismatch_cnt <= '0;
            beat_cnt <= '0;
          end else if (kernel_out_avail) error <= 1'b1;
        end
        SEND: if (in_acc) state <= RECV;
        DONE: begin
          state <= IDLE;
          if (kernel_out_avail) error <= 1'b1;
        end
        default: ;
      endcase
      if (adv) begin
        if (k == LAST) state <= DONE;
        else begin
          k <= k + 16'd1;
          j <= '0;
          state <= SEND;
        end
      end
      if (timeout) begin
        error <= 1'b1;
        state <= DONE;
      end
    end
  end
endmodule
